// File: rtl/dff_pipe_pkg.sv
// Shared constants and helpers for the dff_pipe delay line.
package dff_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  // Bits needed to count 0..depth occupied stages.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_pipe_if.sv
// Control, data and status bundle of the dff_pipe delay line.
interface dff_pipe_if import dff_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) ();

  logic                          en;
  logic                          clr;
  logic [WIDTH-1:0]              din;
  logic                          din_valid;
  logic [WIDTH-1:0]              dout;
  logic                          dout_valid;
  logic [occ_width(DEPTH)-1:0]   occ;
  logic                          changed;

  modport master (
    output en, clr, din, din_valid,
    input  dout, dout_valid, occ, changed
  );

  modport slave (
    input  en, clr, din, din_valid,
    output dout, dout_valid, occ, changed
  );

endinterface

// File: rtl/dff_pipe_stage.sv
// One data word plus valid flag register of the delay line.
module dff_stage import dff_pkg::*; #(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  // Priority: reset, then clear, then advance; otherwise hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q       <= RESET_VAL;
      q_valid <= 1'b0;
    end else if (clr) begin
      q       <= RESET_VAL;
      q_valid <= 1'b0;
    end else if (en) begin
      q       <= d;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/dff_pipe.sv
// Stallable fixed-latency delay line with occupancy count and output change flag.
module dff_pipe import dff_pkg::*; #(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               DEPTH     = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic     clk,
  input  logic     rst,
  dff_pipe_if.slave bus
);

  localparam int OCC_W = occ_width(DEPTH);

  logic [WIDTH-1:0] data [DEPTH];
  logic             vld  [DEPTH];

  logic [OCC_W-1:0] occ_q;
  logic [WIDTH-1:0] last_q;
  logic             have_last_q;
  logic             changed_q;

  // Word that becomes the output on the next enabled edge.
  logic [WIDTH-1:0] tail_d;
  logic             tail_v;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] d_in;
    logic             v_in;
    if (k == 0) begin : g_first
      assign d_in = bus.din;
      assign v_in = bus.din_valid;
    end else begin : g_next
      assign d_in = data[k-1];
      assign v_in = vld[k-1];
    end
    dff_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .clr     (bus.clr),
      .en      (bus.en),
      .d       (d_in),
      .d_valid (v_in),
      .q       (data[k]),
      .q_valid (vld[k])
    );
  end

  if (DEPTH == 1) begin : g_tail_din
    assign tail_d = bus.din;
    assign tail_v = bus.din_valid;
  end else begin : g_tail_stage
    assign tail_d = data[DEPTH-2];
    assign tail_v = vld[DEPTH-2];
  end

  // Occupancy tracks valid words entering and leaving on the same edge;
  // changed compares each new valid output against the previous valid one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q       <= '0;
      last_q      <= RESET_VAL;
      have_last_q <= 1'b0;
      changed_q   <= 1'b0;
    end else if (bus.clr) begin
      occ_q       <= '0;
      last_q      <= RESET_VAL;
      have_last_q <= 1'b0;
      changed_q   <= 1'b0;
    end else if (bus.en) begin
      occ_q     <= occ_q + OCC_W'(bus.din_valid) - OCC_W'(vld[DEPTH-1]);
      changed_q <= tail_v && have_last_q && (tail_d != last_q);
      if (tail_v) begin
        last_q      <= tail_d;
        have_last_q <= 1'b1;
      end
    end else begin
      changed_q <= 1'b0;
    end
  end

  assign bus.dout       = data[DEPTH-1];
  assign bus.dout_valid = vld[DEPTH-1];
  assign bus.occ        = occ_q;
  assign bus.changed    = changed_q;

endmodule

// File: tb/tb_dff_pipe.sv
// Scoreboard bench for dff_pipe: a DEPTH=4/WIDTH=8 and a DEPTH=1/WIDTH=1 instance
// run in lockstep against a queue-based reference model.
module tb_dff_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, clr, din_valid;
  logic [7:0] din;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dff_pipe_if #(.WIDTH(8), .DEPTH(4)) b4 ();
  dff_pipe_if #(.WIDTH(1), .DEPTH(1)) b1 ();

  assign b4.en = en;  assign b4.clr = clr;  assign b4.din = din;     assign b4.din_valid = din_valid;
  assign b1.en = en;  assign b1.clr = clr;  assign b1.din = din[0];  assign b1.din_valid = din_valid;

  dff_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  dff_pipe #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0))  dut1 (.clk(clk), .rst(rst), .bus(b1));

  typedef struct {
    logic [7:0] d;
    logic       v;
    int         occ;
    logic       chg;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];

  // Reference: pipe contents as a queue, front = word on dout; bit 8/1 = valid.
  logic [8:0] m4[$];
  logic [1:0] m1[$];
  logic [7:0] lv4;
  logic       lv1;
  bit         have4, have1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m4.delete();
    m1.delete();
    repeat (4) m4.push_back(9'h000);
    m1.push_back(2'b00);
    lv4 = 8'h00; have4 = 0;
    lv1 = 1'b0;  have1 = 0;
  endtask

  task automatic model_edge(input bit e, input bit c, input logic [7:0] d, input bit v);
    exp_t x4, x1;
    logic ch4, ch1;
    int   n;
    ch4 = 1'b0;
    ch1 = 1'b0;
    if (c) begin
      model_clear();
    end else if (e) begin
      m4.push_back({v, d});
      void'(m4.pop_front());
      m1.push_back({v, d[0]});
      void'(m1.pop_front());
      ch4 = m4[0][8] && have4 && (m4[0][7:0] != lv4);
      if (m4[0][8]) begin lv4 = m4[0][7:0]; have4 = 1; end
      ch1 = m1[0][1] && have1 && (m1[0][0] != lv1);
      if (m1[0][1]) begin lv1 = m1[0][0]; have1 = 1; end
    end
    n = 0;
    foreach (m4[i]) if (m4[i][8]) n++;
    x4.d = m4[0][7:0]; x4.v = m4[0][8]; x4.occ = n; x4.chg = ch4;
    x1.d = {7'b0, m1[0][0]}; x1.v = m1[0][1]; x1.occ = m1[0][1] ? 1 : 0; x1.chg = ch1;
    q4.push_back(x4);
    q1.push_back(x1);
  endtask

  // One clock of stimulus; the expected result is queued at the edge it belongs to.
  task automatic step(input bit e, input bit c, input logic [7:0] d, input bit v);
    en = e; clr = c; din = d; din_valid = v;
    @(posedge clk);
    model_edge(e, c, d, v);
    #1;
  endtask

  // Monitor: compares whatever the DUTs present against the queued expectations.
  always @(negedge clk) begin
    exp_t x;
    if (q4.size() > 0) begin
      x = q4.pop_front();
      chk("d4_dout",       {24'b0, b4.dout},        {24'b0, x.d});
      chk("d4_dout_valid", {31'b0, b4.dout_valid},  {31'b0, x.v});
      chk("d4_occ",        {29'b0, b4.occ},         x.occ);
      chk("d4_changed",    {31'b0, b4.changed},     {31'b0, x.chg});
    end
    if (q1.size() > 0) begin
      x = q1.pop_front();
      chk("d1_dout",       {31'b0, b1.dout},        {24'b0, x.d});
      chk("d1_dout_valid", {31'b0, b1.dout_valid},  {31'b0, x.v});
      chk("d1_occ",        {31'b0, b1.occ},         x.occ);
      chk("d1_changed",    {31'b0, b1.changed},     {31'b0, x.chg});
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dout4"},  {24'b0, b4.dout},       32'h0);
    chk({tag, "_dv4"},    {31'b0, b4.dout_valid}, 32'h0);
    chk({tag, "_occ4"},   {29'b0, b4.occ},        32'h0);
    chk({tag, "_chg4"},   {31'b0, b4.changed},    32'h0);
    chk({tag, "_occ1"},   {31'b0, b1.occ},        32'h0);
    chk({tag, "_dv1"},    {31'b0, b1.dout_valid}, 32'h0);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; clr = 1'b0; din = 8'h00; din_valid = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("init");
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Latency: single valid word followed by bubbles.
    step(1, 0, 8'hA5, 1);
    repeat (5) step(1, 0, 8'($urandom), 0);

    // Stall mid-stream.
    step(1, 0, 8'h01, 1);
    step(1, 0, 8'h02, 1);
    repeat (3) step(0, 0, 8'($urandom), 1);
    step(1, 0, 8'h03, 1);
    step(1, 0, 8'h04, 1);
    repeat (6) step(1, 0, 8'h00, 0);

    // Clear wins over enable with a full pipe.
    for (int i = 0; i < 4; i++) step(1, 0, 8'(8'h30 + i), 1);
    step(1, 1, 8'hFF, 1);
    repeat (5) step(1, 0, 8'h00, 0);

    // Changed flag pattern.
    step(1, 1, 8'h00, 0);
    step(1, 0, 8'h10, 1);
    step(1, 0, 8'h10, 1);
    step(1, 0, 8'h22, 1);
    step(1, 0, 8'h77, 0);
    step(1, 0, 8'h22, 1);
    repeat (4) step(1, 0, 8'h00, 0);

    // Toggling input, exercises the single-stage instance.
    for (int i = 0; i < 12; i++) step(1, 0, 8'(i & 1), 1);
    for (int i = 0; i < 12; i++) step(1, 0, 8'(i & 1), 1'((i >> 1) & 1));

    // Asynchronous reset with a full pipe, checked before the next edge.
    for (int i = 0; i < 4; i++) step(1, 0, 8'(8'hC0 + i), 1);
    @(negedge clk); #1;
    en = 1'b0; clr = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_clear();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    step(1, 0, 8'h5A, 1);
    repeat (5) step(1, 0, 8'h00, 0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
           8'($urandom), 1'($urandom_range(0, 1)));

    @(negedge clk); #1;
    chk("drain_q4", q4.size(), 32'd0);
    chk("drain_q1", q1.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
